matmul_arbiter: RTL and testbench
=================================

MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_V, default 128: width of each packed 4x4 operand/result vector.
REQ-002 The block SHALL have parameter BITS_INDEX, default 8: element width.
REQ-003 The block SHALL have parameter MM_LATENCY, default 1: cycles from operand presentation to a valid mm_result; legal range 1-15.
REQ-004 The block SHALL have ports:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  req0_valid  in  1  requester 0 operation request
  req0_ready  out  1  requester 0 accepted
  req0_a, req0_b  in  WIDTH_V  requester 0 operands
  req1_valid  in  1  requester 1 operation request
  req1_ready  out  1  requester 1 accepted
  req1_a, req1_b  in  WIDTH_V  requester 1 operands
  mm_a, mm_b  out  WIDTH_V  registered operands to the shared matrix-multiply unit
  mm_result  in  WIDTH_V  product from that unit
  rsp_valid  out  1  result available
  rsp_ready  in  1  consumer accepts result
  rsp_data  out  WIDTH_V  captured product
  rsp_id  out  1  requester that owns rsp_data
  busy  out  1  high in any state other than IDLE
  ops_done  out  16  completed-operation count

Function
REQ-005 The FSM SHALL have states IDLE, EXEC and RESP, one request in flight at most.
REQ-006 In IDLE, grant SHALL go to the single valid requester; when both are valid, grant SHALL go to the requester not granted last (round-robin).
REQ-007 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; it SHALL be low in EXEC and RESP.
REQ-008 A handshake (reqN_valid & reqN_ready) at edge T SHALL load mm_a<=reqN_a, mm_b<=reqN_b, rsp_id<=N, last_grant<=N, zero the latency counter, and move to EXEC.
REQ-009 mm_a/mm_b SHALL pass to the unit unmodified and SHALL hold their value until the next accepted request, including after completion.
REQ-010 EXEC SHALL last exactly MM_LATENCY cycles; on its last cycle the edge SHALL capture rsp_data<=mm_result, set rsp_valid, and move to RESP.
REQ-011 With a handshake at edge T, rsp_valid SHALL first be high in the cycle after edge T+MM_LATENCY (MM_LATENCY=1: request accepted cycle 0, rsp_valid high cycle 2).
REQ-012 In RESP, rsp_valid, rsp_data and rsp_id SHALL stay stable until rsp_ready is high; that edge SHALL clear rsp_valid, increment ops_done (wrapping 0xFFFF->0x0000), and return to IDLE.
REQ-013 A request pending during EXEC/RESP SHALL wait; in the cycle after the response handshake it SHALL be arbitrated per REQ-006 (minimum initiation interval MM_LATENCY+2 cycles).
REQ-014 A requester dropping valid before handshake SHALL never be granted for that request; requests SHALL never be lost once accepted.
REQ-015 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-016 rst_n low SHALL immediately force state=IDLE, mm_a=mm_b=0, rsp_data=0, rsp_valid=0, rsp_id=0, busy=0, ops_done=0, latency counter=0, last_grant=1 (requester 0 wins the first tie).
REQ-017 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response produced and no ops_done increment.

Verification
REQ-018 req0 only, a=identity 0x01000000000100000000010000000001, b=0x0102030405060708090A0B0C0D0E0F10, rsp_ready=1 -> rsp_valid cycle 2, rsp_data=b, rsp_id=0, ops_done=1.
REQ-019 Both valid from reset with all-0x03 operands -> req0 served first, then req1; each rsp_data=0x24 in all 16 bytes; rsp_id sequence 0,1.
REQ-020 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req ready low, ops_done unchanged until release.
REQ-021 MM_LATENCY=3, unit model delaying by 3 -> rsp_valid first high 4 cycles after handshake; correct product captured.
REQ-022 rst_n pulsed low mid-EXEC -> all outputs to reset values that cycle; no rsp_valid afterward; next request handled normally.
REQ-023 65536 completed ops -> ops_done wraps to 0x0000.

Source files
------------

// File: rtl/matmul_arbiter.sv
// -----------------------------------------------------------------------------
// matmul_arbiter
//
// Purpose:
//   Shares one matrix-multiply unit between two requesters. A request is
//   granted in IDLE (a lone valid requester wins; on a tie the requester not
//   granted last wins). The accepted operands are registered onto mm_a/mm_b
//   and held there. After MM_LATENCY cycles the unit's product is captured
//   and offered as a response. The arbiter returns to IDLE only when the
//   consumer takes that response. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/a/b  requester 0 handshake and operands
//   req1_valid/ready/a/b  requester 1 handshake and operands
//   mm_a, mm_b            registered operands to the matrix-multiply unit
//   mm_result             product returned by the unit
//   rsp_valid/ready       response handshake
//   rsp_data, rsp_id      captured product and the requester that owns it
//   busy                  high whenever the arbiter is not idle
//   ops_done              wrapping count of completed operations
// -----------------------------------------------------------------------------
module matmul_arbiter #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int MM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH_V-1:0] req0_a,
    input  logic [WIDTH_V-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH_V-1:0] req1_a,
    input  logic [WIDTH_V-1:0] req1_b,
    output logic [WIDTH_V-1:0] mm_a,
    output logic [WIDTH_V-1:0] mm_b,
    input  logic [WIDTH_V-1:0] mm_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH_V-1:0] rsp_data,
    output logic               rsp_id,
    output logic               busy,
    output logic [15:0]        ops_done
);

    // The operand vectors hold a 4x4 matrix of BITS_INDEX-wide elements, and
    // the latency counter is 4 bits wide.
    if ((MM_LATENCY < 1) || (MM_LATENCY > 15)) begin : g_bad_latency
        $error("matmul_arbiter: MM_LATENCY must be within 1..15");
    end
    if (WIDTH_V != (16 * BITS_INDEX)) begin : g_bad_width
        $error("matmul_arbiter: WIDTH_V must equal 16 * BITS_INDEX");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Counter value on the final EXEC cycle (counter starts at zero).
    localparam logic [3:0] LAT_LAST = 4'(MM_LATENCY - 1);

    state_e               state_q,      state_d;
    logic [WIDTH_V-1:0]   mm_a_q,       mm_a_d;
    logic [WIDTH_V-1:0]   mm_b_q,       mm_b_d;
    logic [WIDTH_V-1:0]   rsp_data_q,   rsp_data_d;
    logic                 rsp_valid_q,  rsp_valid_d;
    logic                 rsp_id_q,     rsp_id_d;
    logic                 busy_q,       busy_d;
    logic [15:0]          ops_done_q,   ops_done_d;
    logic [3:0]           lat_cnt_q,    lat_cnt_d;
    logic                 last_grant_q, last_grant_d;

    logic                 grant0_s;
    logic                 grant1_s;

    // Round-robin grant: a lone requester wins; on a tie the requester that
    // was not granted last wins. The two grants are mutually exclusive.
    always_comb begin
        grant0_s = req0_valid & (~req1_valid | last_grant_q);
        grant1_s = req1_valid & (~req0_valid | ~last_grant_q);
    end

    // Next-state, datapath load and request-ready decode.
    always_comb begin
        state_d      = state_q;
        mm_a_d       = mm_a_q;
        mm_b_d       = mm_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        ops_done_d   = ops_done_q;
        lat_cnt_d    = lat_cnt_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is only offered to the granted requester, so a grant
                // is also the handshake.
                req0_ready = grant0_s;
                req1_ready = grant1_s;
                if (grant0_s) begin
                    mm_a_d       = req0_a;
                    mm_b_d       = req0_b;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    lat_cnt_d    = 4'd0;
                    state_d      = ST_EXEC;
                end else if (grant1_s) begin
                    mm_a_d       = req1_a;
                    mm_b_d       = req1_b;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    lat_cnt_d    = 4'd0;
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rsp_data_d  = mm_result;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mm_a_q       <= '0;
            mm_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            busy_q       <= 1'b0;
            ops_done_q   <= 16'd0;
            lat_cnt_q    <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mm_a_q       <= mm_a_d;
            mm_b_q       <= mm_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
            lat_cnt_q    <= lat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_matmul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_matmul_arbiter
//
// Drives two arbiter instances (MM_LATENCY 1 and 3). Each instance is paired
// with a behavioural matrix-multiply unit. A transaction-level reference model
// predicts grants, busy, response timing and the completed count. Accepted
// operations are pushed into a scoreboard. A separate monitor compares every
// presented response against the head of that scoreboard.
// -----------------------------------------------------------------------------
module tb_matmul_arbiter;

    localparam int W   = 128;
    localparam int LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;

    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0] mm_a, mm_b, mm_result, rsp_data;
    logic         rsp_valid, rsp_id, busy;
    logic         rsp_ready = 1'b1;
    logic [15:0]  ops_done;

    logic         l3_req0_valid = 1'b0;
    logic         l3_req0_ready, l3_req1_ready;
    logic [W-1:0] l3_req0_a = '0, l3_req0_b = '0;
    logic [W-1:0] l3_zero = '0;
    logic         l3_low = 1'b0;
    logic         l3_high = 1'b1;
    logic [W-1:0] l3_mm_a, l3_mm_b, l3_mm_result, l3_rsp_data;
    logic         l3_rsp_valid, l3_rsp_id, l3_busy;
    logic [15:0]  l3_ops_done;
    logic [W-1:0] l3_pipe1 = '0, l3_pipe2 = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        logic         id;
    } exp_t;

    exp_t         sb[$];
    logic         id_log[$];
    logic [W-1:0] data_log[$];

    logic         inflight_m = 1'b0;
    logic         last_m     = 1'b1;
    int           age_m      = 0;
    logic [15:0]  done_m     = 16'd0;

    always #5 clk = ~clk;

    matmul_arbiter #(.WIDTH_V(W), .BITS_INDEX(8), .MM_LATENCY(LAT)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mm_a(mm_a), .mm_b(mm_b), .mm_result(mm_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .ops_done(ops_done)
    );

    matmul_arbiter #(.WIDTH_V(W), .BITS_INDEX(8), .MM_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_a(l3_req0_a), .req0_b(l3_req0_b),
        .req1_valid(l3_low), .req1_ready(l3_req1_ready), .req1_a(l3_zero), .req1_b(l3_zero),
        .mm_a(l3_mm_a), .mm_b(l3_mm_b), .mm_result(l3_mm_result),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_high), .rsp_data(l3_rsp_data), .rsp_id(l3_rsp_id),
        .busy(l3_busy), .ops_done(l3_ops_done)
    );

    // 4x4 byte matrix product, element (i,j) at byte 4*i+j counted from the MSB.
    function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [7:0]   s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 8'd0;
                for (int k = 0; k < 4; k++) begin
                    s = s + a[127 - 8*(4*i + k) -: 8] * b[127 - 8*(4*k + j) -: 8];
                end
                r[127 - 8*(4*i + j) -: 8] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Unit models: combinational for latency 1, two register stages for latency 3.
    assign mm_result    = matmul(mm_a, mm_b);
    assign l3_mm_result = l3_pipe2;
    always @(posedge clk) begin
        l3_pipe1 <= matmul(l3_mm_a, l3_mm_b);
        l3_pipe2 <= l3_pipe1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts control outputs and records accepted operations.
    always @(negedge clk) begin
        logic exp_r0, exp_r1, exp_rv;
        if (!rst_n) begin
            inflight_m = 1'b0;
            last_m     = 1'b1;
            age_m      = 0;
            done_m     = 16'd0;
            sb.delete();
        end else begin
            exp_r0 = !inflight_m && req0_valid && (!req1_valid || last_m);
            exp_r1 = !inflight_m && req1_valid && (!req0_valid || !last_m);
            exp_rv = inflight_m && (age_m >= LAT + 1);
            check("req0_ready", req0_ready, exp_r0);
            check("req1_ready", req1_ready, exp_r1);
            check("busy", busy, inflight_m);
            check("rsp_valid", rsp_valid, exp_rv);
            check("ops_done", ops_done, done_m);
            if (exp_r0 || exp_r1) begin
                if (exp_r0) sb.push_back('{a: req0_a, b: req0_b, p: matmul(req0_a, req0_b), id: 1'b0});
                else        sb.push_back('{a: req1_a, b: req1_b, p: matmul(req1_a, req1_b), id: 1'b1});
                inflight_m = 1'b1;
                age_m      = 1;
                last_m     = exp_r1;
            end else if (exp_rv && rsp_ready) begin
                inflight_m = 1'b0;
                done_m     = done_m + 16'd1;
            end else if (inflight_m) begin
                age_m = age_m + 1;
            end
        end
    end

    // Monitor: every presented response must match the oldest accepted operation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=rsp_valid required=no_response at %0t", $time);
            end else begin
                check("rsp_data", rsp_data, sb[0].p);
                check("rsp_id", rsp_id, sb[0].id);
                check("mm_a_hold", mm_a, sb[0].a);
                check("mm_b_hold", mm_b, sb[0].b);
                if (rsp_ready) begin
                    id_log.push_back(rsp_id);
                    data_log.push_back(rsp_data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds each asserted valid until its handshake is seen, within a budget.
    task automatic wait_accept();
        int   n;
        logic h0, h1;
        n = 0;
        while ((req0_valid || req1_valid) && n < 60) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (h0) req0_valid = 1'b0;
            if (h1) req1_valid = 1'b0;
            n++;
        end
        checks++;
        if (req0_valid || req1_valid) begin
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted at %0t", $time);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic pulse_reset();
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ta, tb;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        check("rst_mm_a", mm_a, '0);
        check("rst_mm_b", mm_b, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ops_done", ops_done, 16'd0);
        check("rst_l3_ops_done", l3_ops_done, 16'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Identity times b returns b, response two cycles after request.
        req0_a = 128'h01000000000100000000010000000001;
        req0_b = 128'h0102030405060708090A0B0C0D0E0F10;
        req0_valid = 1'b1;
        wait_accept();
        cyc(3);
        check("ident_rsp_data", data_log[data_log.size()-1], 128'h0102030405060708090A0B0C0D0E0F10);
        check("ident_ops_done", ops_done, 16'd1);

        // Tie from reset: requester 0 first, then requester 1.
        pulse_reset();
        id_log.delete();
        data_log.delete();
        req0_a = {16{8'h03}}; req0_b = {16{8'h03}};
        req1_a = {16{8'h03}}; req1_b = {16{8'h03}};
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_accept();
        cyc(4);
        check("tie_count", id_log.size(), 2);
        if (id_log.size() == 2) begin
            check("tie_first_id", id_log[0], 1'b0);
            check("tie_second_id", id_log[1], 1'b1);
            check("tie_data0", data_log[0], {16{8'h24}});
            check("tie_data1", data_log[1], {16{8'h24}});
        end

        // Consumer stall: response must hold while a new request waits.
        rsp_ready = 1'b0;
        req0_a = rand128(); req0_b = rand128();
        req0_valid = 1'b1;
        wait_accept();
        wait_rsp();
        cyc(1);
        req1_a = rand128(); req1_b = rand128();
        req1_valid = 1'b1;
        cyc(5);
        rsp_ready = 1'b1;
        wait_accept();
        cyc(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = rand128(); req0_b = rand128();
            req1_a = rand128(); req1_b = rand128();
            rsp_ready = $urandom_range(0, 1) != 0;
            cyc(1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        cyc(10);
        check("drain_empty", sb.size(), 0);

        // Completed count wraps past 0xFFFF.
        force dut0.ops_done_q = 16'hFFFE;
        done_m = 16'hFFFE;
        #1 release dut0.ops_done_q;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            req0_a = rand128(); req0_b = rand128();
            req0_valid = 1'b1;
            wait_accept();
            cyc(3);
        end
        check("wrap_ops_done", ops_done, 16'h0000);

        // Reset during EXEC abandons the operation.
        req0_a = rand128() | 128'h1; req0_b = rand128();
        req0_valid = 1'b1;
        wait_accept();
        rst_n = 1'b0;
        #1;
        check("mid_rst_mm_a", mm_a, '0);
        check("mid_rst_mm_b", mm_b, '0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_rsp_data", rsp_data, '0);
        check("mid_rst_rsp_id", rsp_id, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ops_done", ops_done, 16'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        req1_a = rand128(); req1_b = rand128();
        req1_valid = 1'b1;
        wait_accept();
        cyc(4);
        check("post_rst_ops_done", ops_done, 16'd1);

        // Latency-3 instance: response exactly four cycles after the handshake.
        for (int t = 0; t < 2; t++) begin
            cyc(1);
            ta = rand128(); tb = rand128();
            l3_req0_a = ta; l3_req0_b = tb;
            l3_req0_valid = 1'b1;
            @(negedge clk);
            check("l3_ready", l3_req0_ready, 1'b1);
            cyc(1);
            l3_req0_valid = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                check("l3_rsp_valid_timing", l3_rsp_valid, (k == 4));
            end
            check("l3_rsp_data", l3_rsp_data, matmul(ta, tb));
            check("l3_rsp_id", l3_rsp_id, 1'b0);
            cyc(1);
            @(negedge clk);
            check("l3_ops_done", l3_ops_done, 16'(t + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
